// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded grant tenure and a one-cycle turnaround between owners.
// Grant is registered (1 cycle after request); owners release or are revoked after MAX_HOLD cycles.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 expired
);

  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           expired_q, expired_d;

  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic           owner_req;
  logic           hold_max;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin : arb
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IDW'(idx);
      end
    end
  end

  assign owner_req = req[owner_q];
  assign hold_max  = (hold_q == HW'(MAX_HOLD));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    expired_d = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        if (pick_vld) begin
          state_d = GRANT;
          owner_d = pick_idx;
          gnt_d   = N'(1) << pick_idx;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!owner_req || hold_max) begin
          state_d   = TURN;
          gnt_d     = '0;
          hold_d    = '0;
          ptr_d     = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);
          // A release on the expiry cycle is a release, not a revocation.
          expired_d = owner_req && hold_max;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    gnt     = gnt_q;
    gnt_id  = owner_q;
    busy    = |gnt_q;
    expired = expired_q;
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with a cycle-level reference model and per-cycle output comparison.
module tb_rr_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         req;
  logic [N-1:0]         gnt;
  logic [$clog2(N)-1:0] gnt_id;
  logic                 busy;
  logic                 expired;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .expired (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource and for how long, in plain integers.
  int m_owner = -1;
  int m_len   = 0;
  int m_next  = 0;
  bit m_exp   = 1'b0;

  function automatic int first_from(input int start, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner = -1;
      m_len   = 0;
      m_next  = 0;
      m_exp   = 1'b0;
    end else begin
      m_exp = 1'b0;
      if (m_owner >= 0) begin
        if (req[m_owner] && m_len < MAX_HOLD) begin
          m_len++;
        end else begin
          m_exp   = req[m_owner];
          m_next  = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if (req != '0) begin
        m_owner = first_from(m_next, req);
        m_len   = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("expired", 32'(expired), 32'(m_exp));
    if (m_owner >= 0) check("gnt_id", 32'(gnt_id), 32'(m_owner));
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    check("busy_or", 32'(busy), 32'(|gnt));
    if (busy) check("id_match", 32'(gnt[gnt_id]), 32'd1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    req   = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    cyc();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_id", 32'(gnt_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_exp", 32'(expired), 32'd0);
    reset = 1'b1;

    // Two requesters from IDLE; owner 0 releases, turnaround, then 2.
    req = 4'b0101;
    cyc();
    check("r027_gnt0", 32'(gnt), 32'b0001);
    req = 4'b0100;
    cyc();
    check("r027_turn", 32'(gnt), 32'b0000);
    check("r027_noexp", 32'(expired), 32'd0);
    cyc();
    check("r027_gnt2", 32'(gnt), 32'b0100);
    check("r027_id2", 32'(gnt_id), 32'd2);
    req = 4'b0000;
    cyc();
    cyc();
    check("idle_busy", 32'(busy), 32'd0);

    // Single requester held constant: 8 cycles, expiry turnaround, re-grant.
    req = 4'b0010;
    for (int i = 0; i < MAX_HOLD; i++) begin
      cyc();
      check("r028_hold", 32'(gnt), 32'b0010);
    end
    cyc();
    check("r028_turn", 32'(gnt), 32'b0000);
    check("r028_exp", 32'(expired), 32'd1);
    cyc();
    check("r028_regnt", 32'(gnt), 32'b0010);
    check("r028_expclr", 32'(expired), 32'd0);
    req = 4'b0000;
    cyc();
    cyc();

    // Reset restores ptr to 0; all requesting rotates 0,1,2,3,0.
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        cyc();
        check("r029_id", 32'(gnt_id), 32'(o % N));
        check("r029_gnt", 32'(gnt), 32'(1 << (o % N)));
      end
      if (o < 4) begin
        cyc();
        check("r029_turn", 32'(gnt), 32'd0);
        check("r029_exp", 32'(expired), 32'd1);
      end
    end

    // Owner 0 releases on its last cycle; owner 1 then reset mid-grant.
    req = 4'b0010;
    cyc();
    check("r030_relexp", 32'(expired), 32'd0);
    cyc();
    check("r030_gnt1", 32'(gnt), 32'b0010);
    #1 reset = 1'b0;
    #1;
    check("r030_async_gnt", 32'(gnt), 32'd0);
    check("r030_async_busy", 32'(busy), 32'd0);
    check("r030_async_id", 32'(gnt_id), 32'd0);
    req = 4'b1010;
    cyc();
    reset = 1'b1;
    cyc();
    check("r030_after", 32'(gnt), 32'b0010);
    check("r030_after_id", 32'(gnt_id), 32'd1);

    // Owner drops exactly when hold reaches MAX_HOLD: release, not expiry.
    for (int i = 1; i < MAX_HOLD; i++) cyc();
    check("r031_last", 32'(gnt), 32'b0010);
    req = 4'b0000;
    cyc();
    check("r031_turn", 32'(gnt), 32'd0);
    check("r031_noexp", 32'(expired), 32'd0);
    cyc();
    check("r031_idle", 32'(busy), 32'd0);

    // Non-owner request during a grant waits for the turnaround.
    req = 4'b1000;
    cyc();
    check("np_gnt3", 32'(gnt), 32'b1000);
    req = 4'b1001;
    cyc();
    check("np_hold3", 32'(gnt), 32'b1000);
    req = 4'b0001;
    cyc();
    cyc();
    check("np_gnt0", 32'(gnt), 32'b0001);
    req = 4'b0000;
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one grant may be held (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, N bits: req[i] high means requester i wants the shared resource.
REQ-006 The block SHALL have port gnt, output, N bits: one-hot grant, registered, all-zero when no owner.
REQ-007 The block SHALL have port gnt_id, output, clog2(N) bits: index of the current owner, valid only when busy=1.
REQ-008 The block SHALL have port busy, output, 1 bit: high while any grant is asserted.
REQ-009 The block SHALL have port expired, output, 1 bit: one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT and TURN (one-cycle turnaround).
REQ-011 IDLE: if any req bit is high, next state SHALL be GRANT; otherwise it SHALL remain in IDLE.
REQ-012 On IDLE->GRANT, the block SHALL select the first requester with req high, searching from index ptr, ptr+1, ... modulo N.
REQ-013 gnt SHALL assert exactly one cycle after the edge where req was sampled high in IDLE; request-to-grant latency is 1 cycle.
REQ-014 GRANT: the owner SHALL keep gnt while its req stays high and the hold count is below MAX_HOLD.
REQ-015 The hold counter SHALL load 1 on the cycle gnt first asserts and SHALL increment on each following GRANT cycle; it SHALL saturate and never wrap.
REQ-016 GRANT->TURN SHALL occur when the owner drops req (release) or the hold counter equals MAX_HOLD (expiry); gnt SHALL be zero in TURN.
REQ-017 On expiry, with the owner's req still high, expired SHALL pulse high for exactly the first TURN cycle; on release, expired SHALL stay low.
REQ-018 On entry to TURN, ptr SHALL be set to (owner+1) modulo N, wrapping from N-1 to 0.
REQ-019 TURN SHALL always last exactly one cycle: to GRANT if any req is high (arbitration per REQ-012 using the new ptr), otherwise to IDLE.
REQ-020 Requests from non-owners during GRANT SHALL be ignored until TURN; no preemption.
REQ-021 If the owner's req drops and re-rises in the same GRANT cycle, the block SHALL observe only the sampled level; a high sample means the grant is held.
REQ-022 gnt SHALL never have more than one bit set; busy SHALL equal the OR of gnt; gnt_id SHALL match the set bit.
REQ-023 When a single requester holds req high continuously, it SHALL get grants of MAX_HOLD cycles separated by one TURN cycle.

Reset
REQ-024 With reset low, the block SHALL immediately and asynchronously force state=IDLE, gnt=0, gnt_id=0, busy=0, expired=0, ptr=0 and hold counter=0.
REQ-025 Reset asserted mid-grant SHALL drop gnt without a TURN cycle; after reset deasserts, the first grant SHALL use ptr=0.
REQ-026 On the first rising clk edge after reset deasserts, the block SHALL sample req normally; no extra wait state is inserted.

Verification
REQ-027 The bench SHALL cover: N=4, req=0101 from IDLE after reset -> gnt=0001 one cycle later; owner 0 drops req -> TURN (gnt=0000) -> gnt=0100, gnt_id=2.
REQ-028 The bench SHALL cover: MAX_HOLD=8, req=0010 held constant -> gnt=0010 for 8 cycles, 1 cycle gnt=0000 with expired=1, then gnt=0010 again.
REQ-029 The bench SHALL cover: req=1111 held constant -> grant order 0,1,2,3,0, each 8 cycles, separated by single TURN cycles; gnt_id=3 followed by gnt_id=0 (wrap).
REQ-030 The bench SHALL cover: owner 1 granted, assert reset low mid-grant -> gnt=0000 asynchronously, before the next clk edge; release with req=1010 -> gnt=0010 (ptr reset to 0).
REQ-031 The bench SHALL cover: owner drops req on the same cycle that hold reaches MAX_HOLD -> TURN with expired=0; all req low -> IDLE with busy=0.
REQ-032 The bench SHALL check on every cycle that gnt is one-hot or zero, that busy equals the OR of gnt, and that gnt_id is consistent with gnt.
